// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding, bubble word,
// opcode constants used by decode, and the j-type target helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  // j keeps the upper nibble of the jump's own PC+4 region
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: instruction, PC+4 and valid flag with load,
// flush (bubble) and implicit hold. Flush keeps pc4 so a bubble retains its region.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= d_instr;
      pc4   <= d_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to a variable-latency imem via
// req/ready, and feeds IF/ID with stall, branch/jump redirect and a 1-entry skid.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4;
  logic [31:0]  skid_instr, skid_pc4;
  logic         skid_load;
  logic         ifid_load, ifid_flush;
  logic [31:0]  ifid_d_instr, ifid_d_pc4;
  logic         redirect;
  logic [31:0]  target;

  assign pc_plus4  = pc + 32'd4;
  assign redirect  = branch_taken | jump;
  // EX holds the older instruction, so a taken beq wins over a j in ID
  assign target    = branch_taken ? branch_target : jump_target(if_id_pc4, jump_index);
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    skid_load    = 1'b0;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_d_instr = imem_rdata;
    ifid_d_pc4   = pc_plus4;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_next    = target;
            ifid_flush = 1'b1;
          end else if (!id_stall) begin
            ifid_load = 1'b1;
            pc_next   = pc_plus4;
          end else begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect) begin
          pc_next    = target;
          ifid_flush = 1'b1;
          state_next = DISCARD;
        end else if (!id_stall) begin
          ifid_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          ifid_flush = 1'b1;
          state_next = FETCH;
        end else if (!id_stall) begin
          ifid_load    = 1'b1;
          ifid_d_instr = skid_instr;
          ifid_d_pc4   = skid_pc4;
          pc_next      = pc_plus4;
          state_next   = FETCH;
        end
      end
      DISCARD: begin
        // the wrong-path response still has to drain before a new request
        if (redirect) begin
          pc_next    = target;
          ifid_flush = 1'b1;
        end else if (!id_stall) begin
          ifid_flush = 1'b1;
        end
        if (imem_ready) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid_instr <= 32'h0;
      skid_pc4   <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (skid_load) begin
        skid_instr <= imem_rdata;
        skid_pc4   <= pc_plus4;
      end
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .d_instr (ifid_d_instr),
    .d_pc4   (ifid_d_pc4),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4),
    .valid   (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic against a
// transaction-level model of the fetch rules, with a variable-latency imem.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int checks   = 0;
  int failures = 0;

  // memory model state
  bit          mem_busy = 0;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat;
  int          fixed_lat = 1;
  logic        last_req;
  logic [31:0] last_addr;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  bit          m_discard;
  logic [63:0] m_buf[$];

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h1000_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // fetch rules applied one cycle at a time on abstract bookkeeping
  task automatic modelUpdate(input logic rst, input logic ready, input logic [31:0] rdata,
                             input logic stall, input logic br, input logic [31:0] bt,
                             input logic j, input logic [25:0] ji);
    logic        redir;
    logic [31:0] tgt;
    if (!rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_discard = 0; m_buf.delete();
      return;
    end
    redir = br | j;
    tgt   = br ? bt : {m_pc4[31:28], ji, 2'b00};
    if (m_buf.size() != 0) begin
      if (redir) begin
        m_buf.delete(); m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = m_buf[0][63:32]; m_pc4 = m_buf[0][31:0]; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_buf.delete();
      end
    end else if (m_discard) begin
      if (redir) begin
        m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
      if (ready) m_discard = 0;
    end else begin
      if (redir) begin
        m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
        if (!ready) m_discard = 1;
      end else if (ready) begin
        if (stall) m_buf.push_back({rdata, m_pc + 32'd4});
        else begin
          m_instr = rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end else if (!stall) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    logic exp_req;
    exp_req = rst_n && !m_discard && (m_buf.size() == 0);
    check("req",   {31'h0, imem_req},    {31'h0, exp_req});
    check("addr",  imem_addr,            m_pc);
    check("instr", if_id_instr,          m_instr);
    check("pc4",   if_id_pc4,            m_pc4);
    check("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                               input logic [31:0] bt, input logic j, input logic [25:0] ji);
    @(negedge clk);
    rst_n = rst; id_stall = stall; branch_taken = br; branch_target = bt;
    jump = j; jump_index = ji;
    if (!rst) mem_busy = 0;
    #1;
    if (!mem_busy && imem_req === 1'b1) begin
      mem_busy = 1; mem_addr = imem_addr; mem_cnt = 0;
      mem_lat  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
    if (mem_busy) mem_cnt++;
    imem_ready = mem_busy && (mem_cnt >= mem_lat);
    imem_rdata = imem_ready ? memWord(mem_addr) : $urandom;
    last_req   = imem_req;
    last_addr  = imem_addr;
    modelUpdate(rst, imem_ready, imem_rdata, stall, br, bt, j, ji);
    @(posedge clk);
    #1;
    if (imem_ready) mem_busy = 0;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; imem_rdata = 0; id_stall = 0;
    branch_taken = 0; branch_target = 0; jump = 0; jump_index = 0;

    // sequential fetch with a 1-cycle memory
    fixed_lat = 1;
    doReset();
    check("rst_req",   {31'h0, imem_req},    32'h0);
    check("rst_instr", if_id_instr,          32'h0);
    check("rst_pc4",   if_id_pc4,            32'h0);
    check("rst_valid", {31'h0, if_id_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
      check("seq_addr",  last_addr,            32'(i * 4));
      check("seq_pc4",   if_id_pc4,            32'(i * 4 + 4));
      check("seq_valid", {31'h0, if_id_valid}, 32'h1);
    end

    // stall while the word at 8 returns
    doReset();
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(1, 1, 0, 32'h0, 0, 26'h0);
    check("stall_hold_instr", if_id_instr, memWord(32'h4));
    applyStimulus(1, 1, 0, 32'h0, 0, 26'h0);
    check("hold_req",   {31'h0, last_req}, 32'h0);
    check("hold_instr", if_id_instr,       memWord(32'h4));
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    check("release_req",   {31'h0, last_req}, 32'h0);
    check("release_instr", if_id_instr,       memWord(32'h8));
    check("release_pc4",   if_id_pc4,         32'hC);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    check("after_hold_addr", last_addr, 32'hC);

    // taken branch coinciding with a response
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(1, 0, 1, 32'h40, 0, 26'h0);
    check("br_addr",  last_addr,            32'h10);
    check("br_valid", {31'h0, if_id_valid}, 32'h0);
    check("br_instr", if_id_instr,          32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    check("br_target_addr", last_addr, 32'h40);

    // jump while a 3-cycle fetch is outstanding
    doReset();
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    fixed_lat = 3;
    applyStimulus(1, 1, 0, 32'h0, 0, 26'h0);
    check("j_pc4", if_id_pc4, 32'h8);
    applyStimulus(1, 0, 0, 32'h0, 1, 26'h10);
    check("j_valid",       {31'h0, if_id_valid}, 32'h0);
    check("discard_req",   {31'h0, imem_req},    32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    check("discard_drain", {31'h0, last_req},    32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    check("j_new_req",  {31'h0, last_req}, 32'h1);
    check("j_new_addr", last_addr,         32'h40);

    // branch beats jump
    fixed_lat = 1;
    doReset();
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(1, 0, 1, 32'h80, 1, 26'h40);
    check("prio_pc", imem_addr, 32'h80);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    check("prio_addr", last_addr, 32'h80);

    // reset during HOLD
    doReset();
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(1, 1, 0, 32'h0, 0, 26'h0);
    applyStimulus(0, 1, 0, 32'h0, 0, 26'h0);
    check("hrst_instr", if_id_instr,          32'h0);
    check("hrst_pc4",   if_id_pc4,            32'h0);
    check("hrst_valid", {31'h0, if_id_valid}, 32'h0);
    check("hrst_req",   {31'h0, imem_req},    32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    check("hrst_first_req",  {31'h0, last_req}, 32'h1);
    check("hrst_first_addr", last_addr,         32'h0);

    // randomized traffic with variable latency
    $display("[TB] random phase");
    fixed_lat = 0;
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 11) == 0),
                    $urandom,
                    ($urandom_range(0, 11) == 0),
                    26'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
